// File: rtl/pkt_tx_framer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_tx_framer_pkg
//  Description : Shared definitions for the head/data/tail packet interface.
//                Defines the 2-bit beat state encoding that the transmit
//                framer and the receiver FSM both use.
//  Revision    : 1.0 - initial release
// ============================================================================
package pkt_tx_framer_pkg;

    // Beat state encoding on the link:
    // IDLE = no beat, HEAD = first beat, DATA = middle beat, TAIL = last beat.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HEAD = 2'b01,
        ST_DATA = 2'b10,
        ST_TAIL = 2'b11
    } pkt_state_e;

    // Every packet carries at least a head and a tail beat.
    localparam int c_min_beats = 2;

endpackage : pkt_tx_framer_pkg
`default_nettype wire

// File: rtl/pkt_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_tx_framer
//  Description : Transmit-side packet framer. Turns a start request plus a
//                beat count into one head beat, zero or more data beats and
//                one tail beat, pulling one payload word from upstream for
//                every beat. Beats advance only on valid & ready.
//  Options     : PKT_TX_IFG_EN - when defined, a tail transfer is followed by
//                IFG idle-gap cycles and back-to-back packets are disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module pkt_tx_framer
    import pkt_tx_framer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4,
    parameter int IFG    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] din,
    output logic              din_rd,
    input  logic              ready,
    output logic              valid,
    output logic              head,
    output logic              tail,
    output logic [DATA_W-1:0] dout,
    output logic              start_ack,
    output logic [1:0]        state
);

`ifdef PKT_TX_IFG_EN
    localparam bit c_ifg_en = 1'b1;
`else
    localparam bit c_ifg_en = 1'b0;
`endif

    // Length of the post-tail gap; zero when the gap feature is compiled out.
    localparam int c_gap_len = c_ifg_en ? IFG : 0;
    localparam int c_gap_w   = (c_gap_len < 2) ? 1 : $clog2(c_gap_len + 1);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    pkt_state_e          r_state;
    logic [LEN_W-1:0]    r_rem;       // beats still to send after the presented one
    logic [c_gap_w-1:0]  r_gap_cnt;   // nonzero = inside the inter-frame gap
    logic                r_valid;
    logic                r_head;
    logic                r_tail;
    logic                r_start_ack;
    logic [DATA_W-1:0]   r_dout;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    pkt_state_e          w_state_nxt;
    logic [LEN_W-1:0]    w_rem_nxt;
    logic [c_gap_w-1:0]  w_gap_nxt;
    logic [LEN_W-1:0]    w_len_c;
    logic                w_xfer;
    logic                w_idle_open;
    logic                w_tail_accept;
    logic                w_accept;
    logic                w_advance;
    logic                w_load;

    // A beat moves on the link only when presented and accepted.
    assign w_xfer = r_valid & ready;

    // Short requests are stretched to the minimum head+tail packet.
    assign w_len_c = (len < LEN_W'(c_min_beats)) ? LEN_W'(c_min_beats) : len;

    // A new packet may start from a true idle cycle (gap expired) or, when
    // back-to-back is allowed, on the cycle the tail beat is accepted.
    assign w_idle_open   = (r_state == ST_IDLE) && (r_gap_cnt == '0);
    assign w_tail_accept = (r_state == ST_TAIL) && w_xfer && !c_ifg_en;
    assign w_accept      = start && (w_idle_open || w_tail_accept);

    // Head and data beats that leave pull the following word from upstream.
    assign w_advance = w_xfer && ((r_state == ST_HEAD) || (r_state == ST_DATA));

    // One upstream word is consumed per head load and per beat advance.
    assign w_load = w_accept || w_advance;
    assign din_rd = !reset && w_load;

    // Next-state selection for the beat sequencer and its counters.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_gap_nxt   = r_gap_cnt;
        case (r_state)
            ST_IDLE: begin
                if (r_gap_cnt != '0) begin
                    w_gap_nxt = r_gap_cnt - c_gap_w'(1);
                end else if (start) begin
                    w_state_nxt = ST_HEAD;
                    w_rem_nxt   = w_len_c - LEN_W'(1);
                end
            end
            ST_HEAD, ST_DATA: begin
                if (w_xfer) begin
                    w_state_nxt = (r_rem == LEN_W'(1)) ? ST_TAIL : ST_DATA;
                    w_rem_nxt   = r_rem - LEN_W'(1);
                end
            end
            ST_TAIL: begin
                if (w_xfer) begin
                    if (w_accept) begin
                        w_state_nxt = ST_HEAD;
                        w_rem_nxt   = w_len_c - LEN_W'(1);
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_gap_nxt   = c_gap_w'(c_gap_len);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sequencer register; link outputs are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rem       <= '0;
            r_gap_cnt   <= '0;
            r_valid     <= 1'b0;
            r_head      <= 1'b0;
            r_tail      <= 1'b0;
            r_start_ack <= 1'b0;
            r_dout      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rem       <= w_rem_nxt;
            r_gap_cnt   <= w_gap_nxt;
            r_valid     <= (w_state_nxt != ST_IDLE);
            r_head      <= (w_state_nxt == ST_HEAD);
            r_tail      <= (w_state_nxt == ST_TAIL);
            r_start_ack <= w_accept;
            if (w_load) begin
                r_dout <= din;
            end
        end
    end

    assign valid     = r_valid;
    assign head      = r_head;
    assign tail      = r_tail;
    assign dout      = r_dout;
    assign start_ack = r_start_ack;
    assign state     = r_state;

endmodule : pkt_tx_framer
`default_nettype wire
